// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N-to-1 valid/ready stream multiplexer with a registered output stage.
//   mode=0 forwards the channel named by sel. mode=1 runs a round-robin
//   arbiter that starts its search at a rotating pointer. One word can move
//   per cycle, and a word reaches the output one clock after it is accepted.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used when mode=0
//   in_data    packed payloads, channel i at [i*DATA_W +: DATA_W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational)
//   out_data   registered payload
//   out_ch     registered index of the source channel
//   out_valid  registered valid
//   out_ready  downstream ready
module stream_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [$clog2(NUM_CH)-1:0]  sel,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int SEL_W = $clog2(NUM_CH);

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [DATA_W-1:0] out_data_reg;
  logic [SEL_W-1:0]  out_ch_reg;
  logic              out_valid_reg;
  logic [SEL_W-1:0]  ptr_reg;
  logic [SEL_W-1:0]  ptr_next;

  logic              load_en;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant;
  logic              xfer;
  int                scan_idx;
  logic [SEL_W-1:0]  scan_ch;

  // Unpack the flat payload bus into one word per channel.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // The output register can take a word when it is empty or draining now.
  assign load_en = !out_valid_reg || out_ready;

  // Grant selection. In round-robin mode the scan starts at ptr_reg and wraps,
  // so the channel served last has the lowest priority on the next pick.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    scan_idx    = 0;
    scan_ch     = '0;
    if (!mode) begin
      if (int'(sel) < NUM_CH) begin
        grant_valid = 1'b1;
        grant       = sel;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        scan_idx = int'(ptr_reg) + k;
        if (scan_idx >= NUM_CH) begin
          scan_idx = scan_idx - NUM_CH;
        end
        scan_ch = SEL_W'(scan_idx);
        if (!grant_valid && in_valid[scan_ch]) begin
          grant_valid = 1'b1;
          grant       = scan_ch;
        end
      end
    end
  end

  // Only the granted channel may see ready. In fixed mode this does not
  // depend on that channel's valid.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
      assign in_ready[gi] = grant_valid && (grant == SEL_W'(gi)) && load_en && !rst;
    end
  endgenerate

  assign xfer = grant_valid && in_valid[grant] && load_en && !rst;

  assign ptr_next = (int'(grant) == NUM_CH - 1) ? '0 : grant + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else begin
      if (xfer) begin
        out_data_reg  <= ch_data[grant];
        out_ch_reg    <= grant;
        out_valid_reg <= 1'b1;
        // The pointer only moves on round-robin wins, so fixed-mode traffic
        // leaves the arbitration history untouched.
        if (mode) begin
          ptr_reg <= ptr_next;
        end
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign out_valid = out_valid_reg;

endmodule
